// File: rtl/link_reset_supervisor.sv
// Runtime reset sequencer for the DCM and Aurora link: brings the link up, holds the
// datapath in reset until channel-up, and re-runs the sequence on loss with bounded retries.
module link_reset_supervisor #(
  parameter int DCM_RST_CYCLES    = 128,
  parameter int AURORA_RST_CYCLES = 128,
  parameter int LOCK_TIMEOUT      = 4096,
  parameter int CHANNEL_TIMEOUT   = 65536,
  parameter int HOLDOFF_CYCLES    = 1024,
  parameter int MAX_RETRIES       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcm_locked,
  input  logic        channel_up,
  input  logic        force_reinit,
  input  logic        clear_fault,
  output logic        rst_dcm,
  output logic        rst_aurora,
  output logic        rst_datapath,
  output logic        ready,
  output logic        fault,
  output logic [3:0]  retry_count,
  output logic [15:0] reinit_count
);

  typedef enum logic [2:0] {
    S_RESET_DCM,
    S_WAIT_LOCK,
    S_RESET_AURORA,
    S_WAIT_CHANNEL,
    S_RUN,
    S_RETRY,
    S_HOLDOFF,
    S_FAULT
  } state_t;

  // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
  localparam logic [16:0] DCM_LAST     = 17'(DCM_RST_CYCLES - 1);
  localparam logic [16:0] AURORA_LAST  = 17'(AURORA_RST_CYCLES - 1);
  localparam logic [16:0] LOCK_LAST    = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] CHANNEL_LAST = 17'(CHANNEL_TIMEOUT - 1);
  localparam logic [16:0] HOLDOFF_LAST = 17'(HOLDOFF_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [16:0] timer_q;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] reinit_q, reinit_d;

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    reinit_d = reinit_q;
    case (state_q)
      S_RESET_DCM: begin
        if (timer_q == DCM_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (dcm_locked)                 state_d = S_RESET_AURORA;
        else if (timer_q == LOCK_LAST)  state_d = S_RETRY;
      end
      S_RESET_AURORA: begin
        if (!dcm_locked)                  state_d = S_RETRY;
        else if (timer_q == AURORA_LAST)  state_d = S_WAIT_CHANNEL;
      end
      S_WAIT_CHANNEL: begin
        if (!dcm_locked) begin
          state_d = S_RETRY;
        end else if (channel_up) begin
          state_d = S_RUN;
          retry_d = '0;
        end else if (timer_q == CHANNEL_LAST) begin
          state_d = S_RETRY;
        end
      end
      S_RUN: begin
        if (!dcm_locked || !channel_up || force_reinit) begin
          state_d = S_HOLDOFF;
          if (reinit_q != 16'hFFFF) reinit_d = reinit_q + 16'd1;
        end
      end
      S_RETRY: begin
        if (retry_q == RETRY_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_HOLDOFF;
          retry_d = retry_q + 4'd1;
        end
      end
      S_HOLDOFF: begin
        if (timer_q == HOLDOFF_LAST) state_d = S_RESET_DCM;
      end
      S_FAULT: begin
        if (clear_fault || force_reinit) begin
          state_d = S_RESET_DCM;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET_DCM;
    endcase
  end

  // Timer restarts on every state change; wrapping in RUN/FAULT is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RESET_DCM;
      timer_q  <= '0;
      retry_q  <= '0;
      reinit_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= (state_d != state_q) ? 17'd0 : timer_q + 17'd1;
      retry_q  <= retry_d;
      reinit_q <= reinit_d;
    end
  end

  assign rst_dcm      = (state_q == S_RESET_DCM) || (state_q == S_HOLDOFF) ||
                        (state_q == S_FAULT);
  assign rst_aurora   = (state_q != S_WAIT_CHANNEL) && (state_q != S_RUN);
  assign rst_datapath = (state_q != S_RUN);
  assign ready        = (state_q == S_RUN);
  assign fault        = (state_q == S_FAULT);
  assign retry_count  = retry_q;
  assign reinit_count = reinit_q;

endmodule

// File: tb/tb_link_reset_supervisor.sv
// Bench for link_reset_supervisor: directed timing scenarios plus a randomized run
// compared against a phase/countdown reference model.
module tb_link_reset_supervisor;

  localparam int DCM = 8, AUR = 8, LT = 32, CT = 64, HO = 16, MR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dcm_locked = 1'b0, channel_up = 1'b0, force_reinit = 1'b0, clear_fault = 1'b0;
  logic        rst_dcm, rst_aurora, rst_datapath, ready, fault;
  logic [3:0]  retry_count;
  logic [15:0] reinit_count;
  logic [4:0]  outs;

  link_reset_supervisor #(
    .DCM_RST_CYCLES(DCM), .AURORA_RST_CYCLES(AUR), .LOCK_TIMEOUT(LT),
    .CHANNEL_TIMEOUT(CT), .HOLDOFF_CYCLES(HO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst(rst), .dcm_locked(dcm_locked), .channel_up(channel_up),
    .force_reinit(force_reinit), .clear_fault(clear_fault),
    .rst_dcm(rst_dcm), .rst_aurora(rst_aurora), .rst_datapath(rst_datapath),
    .ready(ready), .fault(fault), .retry_count(retry_count), .reinit_count(reinit_count)
  );

  always #5 clk = ~clk;

  assign outs = {rst_dcm, rst_aurora, rst_datapath, ready, fault};

  // Output patterns {rst_dcm, rst_aurora, rst_datapath, ready, fault}
  localparam logic [4:0] O_ALLRST = 5'b11100;
  localparam logic [4:0] O_AURRST = 5'b01100;
  localparam logic [4:0] O_WCHAN  = 5'b00100;
  localparam logic [4:0] O_RUN    = 5'b00010;
  localparam logic [4:0] O_FAULT  = 5'b11101;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Reference model: named phase plus cycles remaining in that phase.
  localparam int P_RD = 0, P_WL = 1, P_RA = 2, P_WC = 3, P_RUN = 4, P_RT = 5, P_HO = 6, P_FA = 7;
  int m_phase = P_RD, m_left = DCM, m_retry = 0, m_reinit = 0;

  function automatic logic [4:0] m_outs(input int p);
    case (p)
      P_RD, P_HO:       return O_ALLRST;
      P_WL, P_RA, P_RT: return O_AURRST;
      P_WC:             return O_WCHAN;
      P_RUN:            return O_RUN;
      default:          return O_FAULT;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = P_RD; m_left = DCM; m_retry = 0; m_reinit = 0;
    end else begin
      case (m_phase)
        P_RD: if (m_left == 1) begin m_phase = P_WL; m_left = LT; end else m_left--;
        P_WL: if (dcm_locked) begin m_phase = P_RA; m_left = AUR; end
              else if (m_left == 1) m_phase = P_RT; else m_left--;
        P_RA: if (!dcm_locked) m_phase = P_RT;
              else if (m_left == 1) begin m_phase = P_WC; m_left = CT; end else m_left--;
        P_WC: if (!dcm_locked) m_phase = P_RT;
              else if (channel_up) begin m_phase = P_RUN; m_retry = 0; end
              else if (m_left == 1) m_phase = P_RT; else m_left--;
        P_RUN: if (!dcm_locked || !channel_up || force_reinit) begin
                 m_phase = P_HO; m_left = HO;
                 if (m_reinit < 65535) m_reinit++;
               end
        P_RT: if (m_retry == MR) m_phase = P_FA;
              else begin m_retry++; m_phase = P_HO; m_left = HO; end
        P_HO: if (m_left == 1) begin m_phase = P_RD; m_left = DCM; end else m_left--;
        default: if (clear_fault || force_reinit) begin
                   m_phase = P_RD; m_left = DCM; m_retry = 0;
                 end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset(input logic lk, input logic ch);
    rst = 1'b1; dcm_locked = lk; channel_up = ch; force_reinit = 1'b0; clear_fault = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; dcm_locked = 1'b1; channel_up = 1'b1; force_reinit = 1'b1; clear_fault = 1'b1;
    tick();
    vectors++;
    if ({outs, retry_count, reinit_count} !== {O_ALLRST, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_values outs=%b retry=%0d reinit=%0d want outs=%b retry=0 reinit=0",
               outs, retry_count, reinit_count, O_ALLRST);
    end
    apply_reset(1'b1, 1'b1);
    vectors++;
    if (outs !== O_ALLRST) begin
      miscompares++;
      $display("FAIL reset_cycle0 outs=%b want=%b", outs, O_ALLRST);
    end
  endtask

  task automatic test_nominal();
    logic [4:0] e;
    apply_reset(1'b1, 1'b1);
    for (int c = 0; c < 25; c++) begin
      e = {c <= 7, c <= 16, c < 18, c >= 18, 1'b0};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL nominal cyc=%0d outs=%b want=%b", cyc, outs, e);
      end
      tick();
    end
  endtask

  task automatic test_lock_timeout();
    logic [5:0] e;
    apply_reset(1'b0, 1'b0);
    for (int c = 0; c < 160; c++) begin
      e = {c >= 155, 1'b0, (c <= 40) ? 4'd0 : (c <= 97) ? 4'd1 : 4'd2};
      vectors++;
      if ({fault, ready, retry_count} !== e) begin
        miscompares++;
        $display("FAIL lock_timeout cyc=%0d fault/ready/retry=%b want=%b",
                 cyc, {fault, ready, retry_count}, e);
      end
      tick();
    end
    clear_fault = 1'b1; dcm_locked = 1'b1; channel_up = 1'b1;
    tick();
    clear_fault = 1'b0;
    vectors++;
    if ({outs, retry_count} !== {O_ALLRST, 4'd0}) begin
      miscompares++;
      $display("FAIL clear_fault outs=%b retry=%0d want outs=%b retry=0", outs, retry_count, O_ALLRST);
    end
    for (int r = 1; r <= 18; r++) begin
      tick();
      if (r >= 17) begin
        vectors++;
        if (ready !== (r == 18)) begin
          miscompares++;
          $display("FAIL fault_recover rel=%0d ready=%b want=%b", r, ready, r == 18);
        end
      end
    end
  endtask

  task automatic test_fault_force();
    apply_reset(1'b0, 1'b0);
    run_to(156);
    vectors++;
    if (outs !== O_FAULT) begin
      miscompares++;
      $display("FAIL fault_state outs=%b want=%b", outs, O_FAULT);
    end
    force_reinit = 1'b1;
    tick();
    force_reinit = 1'b0;
    vectors++;
    if ({outs, retry_count} !== {O_ALLRST, 4'd0}) begin
      miscompares++;
      $display("FAIL fault_force outs=%b retry=%0d want outs=%b retry=0", outs, retry_count, O_ALLRST);
    end
  endtask

  task automatic test_channel_timeout();
    logic [8:0] e;
    apply_reset(1'b1, 1'b0);
    for (int c = 0; c <= 116; c++) begin
      if (c == 90) channel_up = 1'b1;
      e = 9'h1FF;
      case (c)
        80:  e = {O_WCHAN, 4'd0};
        81:  e = {O_AURRST, 4'd0};
        82:  e = {O_ALLRST, 4'd1};
        115: e = {O_WCHAN, 4'd1};
        116: e = {O_RUN, 4'd0};
        default: ;
      endcase
      if (e != 9'h1FF) begin
        vectors++;
        if ({outs, retry_count} !== e) begin
          miscompares++;
          $display("FAIL chan_timeout cyc=%0d outs/retry=%b want=%b", cyc, {outs, retry_count}, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_loss_in_run();
    apply_reset(1'b1, 1'b1);
    run_to(20);
    channel_up = 1'b0; tick(); channel_up = 1'b1;
    vectors++;
    if ({outs, reinit_count} !== {O_ALLRST, 16'd1}) begin
      miscompares++;
      $display("FAIL chan_loss outs=%b reinit=%0d want outs=%b reinit=1", outs, reinit_count, O_ALLRST);
    end
    run_to(54);
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL chan_loss_early ready=%b want=0", ready); end
    tick();
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL chan_loss_back ready=%b want=1", ready); end
    run_to(60);
    dcm_locked = 1'b0; tick(); dcm_locked = 1'b1;
    vectors++;
    if ({outs, reinit_count} !== {O_ALLRST, 16'd2}) begin
      miscompares++;
      $display("FAIL lock_loss outs=%b reinit=%0d want outs=%b reinit=2", outs, reinit_count, O_ALLRST);
    end
    run_to(94);
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL lock_loss_early ready=%b want=0", ready); end
    tick();
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL lock_loss_back ready=%b want=1", ready); end
  endtask

  task automatic test_priority();
    // force_reinit in RUN
    apply_reset(1'b1, 1'b1);
    run_to(20);
    force_reinit = 1'b1; tick(); force_reinit = 1'b0;
    vectors++;
    if ({outs, reinit_count} !== {O_ALLRST, 16'd1}) begin
      miscompares++;
      $display("FAIL force_run outs=%b reinit=%0d want outs=%b reinit=1", outs, reinit_count, O_ALLRST);
    end
    // force_reinit in WAIT_LOCK is ignored
    apply_reset(1'b0, 1'b0);
    run_to(10);
    force_reinit = 1'b1; tick(); force_reinit = 1'b0;
    vectors++;
    if (outs !== O_AURRST) begin
      miscompares++;
      $display("FAIL force_waitlock outs=%b want=%b", outs, O_AURRST);
    end
    run_to(40);
    vectors++;
    if ({outs, retry_count} !== {O_AURRST, 4'd0}) begin
      miscompares++;
      $display("FAIL force_waitlock_retry outs/retry=%b want=%b", {outs, retry_count}, {O_AURRST, 4'd0});
    end
    tick();
    vectors++;
    if ({outs, retry_count} !== {O_ALLRST, 4'd1}) begin
      miscompares++;
      $display("FAIL force_waitlock_hold outs/retry=%b want=%b", {outs, retry_count}, {O_ALLRST, 4'd1});
    end
    // lock loss beats channel_up in WAIT_CHANNEL
    apply_reset(1'b1, 1'b0);
    run_to(20);
    dcm_locked = 1'b0; channel_up = 1'b1; tick(); dcm_locked = 1'b1;
    vectors++;
    if (outs !== O_AURRST) begin
      miscompares++;
      $display("FAIL wc_priority outs=%b want=%b", outs, O_AURRST);
    end
    tick();
    vectors++;
    if ({outs, retry_count} !== {O_ALLRST, 4'd1}) begin
      miscompares++;
      $display("FAIL wc_priority_hold outs/retry=%b want=%b", {outs, retry_count}, {O_ALLRST, 4'd1});
    end
    // lock on the timeout cycle wins
    apply_reset(1'b0, 1'b1);
    run_to(39);
    dcm_locked = 1'b1;
    tick(); tick();
    vectors++;
    if ({outs, retry_count} !== {O_AURRST, 4'd0}) begin
      miscompares++;
      $display("FAIL lock_on_timeout outs/retry=%b want=%b", {outs, retry_count}, {O_AURRST, 4'd0});
    end
    run_to(48);
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL lock_on_timeout_early ready=%b want=0", ready); end
    tick();
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL lock_on_timeout_run ready=%b want=1", ready); end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b1, 1'b1);
    run_to(12);
    rst = 1'b1; tick(); rst = 1'b0; cyc = 0;
    vectors++;
    if ({outs, retry_count, reinit_count} !== {O_ALLRST, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_in_ra outs=%b retry=%0d reinit=%0d want outs=%b 0 0",
               outs, retry_count, reinit_count, O_ALLRST);
    end
    run_to(20);
    force_reinit = 1'b1; tick(); force_reinit = 1'b0;
    run_to(56);
    vectors++;
    if ({ready, reinit_count} !== {1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL pre_reset_run ready=%b reinit=%0d want ready=1 reinit=1", ready, reinit_count);
    end
    rst = 1'b1; tick(); rst = 1'b0; cyc = 0;
    vectors++;
    if ({outs, retry_count, reinit_count} !== {O_ALLRST, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_in_run outs=%b retry=%0d reinit=%0d want outs=%b 0 0",
               outs, retry_count, reinit_count, O_ALLRST);
    end
  endtask

  task automatic test_random();
    logic lock_ok = 1'b1, chan_ok = 1'b1;
    apply_reset(1'b1, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) lock_ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) chan_ok = ($urandom_range(0, 3) != 0);
      dcm_locked   = lock_ok && ($urandom_range(0, 399) != 0);
      channel_up   = chan_ok && ($urandom_range(0, 399) != 0);
      force_reinit = ($urandom_range(0, 299) == 0);
      clear_fault  = ($urandom_range(0, 99) == 0);
      rst          = ($urandom_range(0, 1999) == 0);
      tick();
      vectors++;
      if ({outs, retry_count, reinit_count} !== {m_outs(m_phase), 4'(m_retry), 16'(m_reinit)}) begin
        miscompares++;
        $display("FAIL random step=%0d outs=%b retry=%0d reinit=%0d want outs=%b retry=%0d reinit=%0d",
                 i, outs, retry_count, reinit_count, m_outs(m_phase), m_retry, m_reinit);
      end
    end
    rst = 1'b0; force_reinit = 1'b0; clear_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_timeout();
    test_fault_force();
    test_channel_timeout();
    test_loss_in_run();
    test_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/link_reset_supervisor.md
# link_reset_supervisor

Runtime reset supervisor for the DCM and Aurora link of the trigger-consolidation FPGA. It sequences DCM reset, lock wait, Aurora reset and channel-up wait, then holds the datapath (FIFOs, sorter, trigger) in reset until the link is up. After bring-up it monitors lock and channel, re-runs the sequence on loss with bounded retries and holdoff, and latches a fault when the retry budget is exhausted.

## Interface
- DCM_RST_CYCLES, 128: cycles rst_dcm is held in RESET_DCM.
- AURORA_RST_CYCLES, 128: cycles rst_aurora is held alone in RESET_AURORA.
- LOCK_TIMEOUT, 4096: maximum cycles spent in WAIT_LOCK.
- CHANNEL_TIMEOUT, 65536: maximum cycles spent in WAIT_CHANNEL.
- HOLDOFF_CYCLES, 1024: cycles all resets are held between attempts.
- MAX_RETRIES, 3: failed attempts retried before FAULT (range 0–15).
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- dcm_locked  in  1  DCM lock status, synchronous to clk.
- channel_up  in  1  Aurora channel-up status, synchronous to clk.
- force_reinit  in  1  single-cycle request to re-run the sequence.
- clear_fault  in  1  single-cycle request to leave FAULT.
- rst_dcm  out  1  DCM reset.
- rst_aurora  out  1  Aurora reset.
- rst_datapath  out  1  reset for FIFOs, sorter and trigger.
- ready  out  1  link up, datapath released.
- fault  out  1  retry budget exhausted.
- retry_count  out  4  failed attempts since last RUN or clear_fault.
- reinit_count  out  16  RUN exits, saturating at 0xFFFF.

## Operation
- States: RESET_DCM, WAIT_LOCK, RESET_AURORA, WAIT_CHANNEL, RUN, RETRY, HOLDOFF, FAULT.
- Outputs are decoded from the registered state. There is no combinational path from any input to any output.
  - rst_dcm = RESET_DCM, HOLDOFF or FAULT.
  - rst_aurora = RESET_DCM, WAIT_LOCK, RESET_AURORA, RETRY, HOLDOFF or FAULT.
  - rst_datapath = not RUN.
  - ready = RUN.
  - fault = FAULT.
- A single 17-bit timer is cleared on every state change and increments otherwise.
- RESET_DCM: go to WAIT_LOCK after DCM_RST_CYCLES cycles.
- WAIT_LOCK:
  - dcm_locked=1 → RESET_AURORA.
  - Otherwise, after LOCK_TIMEOUT cycles → RETRY.
  - Lock wins over timeout in the same cycle.
- RESET_AURORA:
  - dcm_locked=0 → RETRY.
  - Otherwise, after AURORA_RST_CYCLES cycles → WAIT_CHANNEL.
- WAIT_CHANNEL, in priority order:
  - dcm_locked=0 → RETRY.
  - channel_up=1 → RUN.
  - Timeout after CHANNEL_TIMEOUT cycles → RETRY.
- RUN:
  - Entry clears retry_count.
  - dcm_locked=0, channel_up=0 or force_reinit=1 → HOLDOFF, and reinit_count increments (saturating).
- RETRY (one cycle):
  - If retry_count == MAX_RETRIES → FAULT.
  - Else retry_count+1 → HOLDOFF.
- HOLDOFF: go to RESET_DCM after HOLDOFF_CYCLES cycles.
- FAULT: clear_fault or force_reinit → RESET_DCM, and retry_count clears.
- Ignored inputs:
  - force_reinit outside RUN and FAULT.
  - clear_fault outside FAULT.
- Parameters with a value of 0 or greater than 65536 are illegal.

## Timing
- During rst and after reset: state RESET_DCM, timer 0, retry_count 0, reinit_count 0.
- Reset output values: rst_dcm=1, rst_aurora=1, rst_datapath=1, ready=0, fault=0.
- Reset mid-operation returns to these values on the next edge, regardless of state.
- Cycle 0 is the first cycle after rst deasserts.
- Nominal bring-up (lock and channel already high) reaches RUN at cycle DCM_RST_CYCLES+1+AURORA_RST_CYCLES+1.
- WAIT_LOCK and WAIT_CHANNEL last at least one cycle.
- Loss in RUN sampled at cycle n: ready=0 and all resets=1 at cycle n+1.
- Each failed lock-timeout attempt lasts DCM_RST_CYCLES+LOCK_TIMEOUT+1+HOLDOFF_CYCLES cycles.
- retry_count updates on the edge leaving RETRY.

## Test plan
Bench parameters: DCM=8, AURORA=8, LOCK_TIMEOUT=32, CHANNEL_TIMEOUT=64, HOLDOFF=16, MAX_RETRIES=2.

- Nominal bring-up: dcm_locked=1, channel_up=1 from reset → rst_dcm high cycles 0–7, rst_aurora high cycles 0–16, ready=1 and rst_datapath=0 from cycle 18.
- Lock never arrives: dcm_locked=0 → RETRY at 40 and 97 (retry_count 1, then 2), FAULT at 155, fault=1, retry_count=2; then clear_fault with lock=1 → RESET_DCM, retry_count=0, ready returns.
- Channel timeout then recovery: channel_up=0 for the first attempt → RETRY after 64 WAIT_CHANNEL cycles, retry_count=1; channel_up=1 on the second attempt → RUN, retry_count=0.
- Loss in RUN: drop channel_up for one cycle at cycle n → ready=0 at n+1, 16 HOLDOFF cycles, full resequence, reinit_count=1; drop dcm_locked in RUN → same behaviour, reinit_count=2.
- Priority cases:
  - force_reinit in RUN → HOLDOFF.
  - force_reinit in WAIT_LOCK → ignored.
  - dcm_locked=0 and channel_up=1 in the same WAIT_CHANNEL cycle → RETRY.
  - Lock arriving on the timeout cycle → RESET_AURORA.
- Reset mid-sequence: assert rst in RESET_AURORA and in RUN → all outputs at reset values next edge; reinit_count=0.
